// File: rtl/mul_pipe_issue_ctrl.sv
// Issue/capture controller wrapped around a free-running 32x32 multiplier.
// Operands go straight to the multiplier on accept. A valid/tag chain matched
// to the multiplier latency marks when each product shows up on mul_out, and
// that product is written into a show-ahead FIFO. Admission is credit based:
// an op is taken only if every op already in the chain or the FIFO still has a
// guaranteed slot, because the pipeline cannot stall.
module mul_pipe_issue_ctrl #(
  parameter int LATENCY = 7,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              mul_a,
  output logic [31:0]              mul_b,
  input  logic [63:0]              mul_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_prod,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0]            r_vld_pipe;
  logic [LATENCY-1:0][TAG_W-1:0] r_tag_pipe;
  logic [63:0]                   r_mem_prod [DEPTH];
  logic [TAG_W-1:0]              r_mem_tag  [DEPTH];
  logic [AW-1:0]                 r_wr_ptr;
  logic [AW-1:0]                 r_rd_ptr;
  logic [CW-1:0]                 r_cnt;
  logic [CW-1:0]                 r_infl;

  logic [CW:0] w_pending;
  logic        w_credit;
  logic        w_accept;
  logic        w_accept_d;
  logic        w_push;
  logic        w_pop;

  // Pending counts both the chain and the FIFO, so sustained one-per-cycle
  // issue with a continuously draining consumer needs DEPTH > LATENCY + 1.
  assign w_pending = {1'b0, r_infl} + {1'b0, r_cnt};
  assign w_credit  = (w_pending < (CW+1)'(DEPTH));
  assign in_ready  = reset & w_credit;
  assign w_accept  = in_valid & in_ready;
  // Flop-side accept leaves reset out of the data path; while reset is low
  // every flop it feeds is held cleared anyway.
  assign w_accept_d = in_valid & w_credit;

  assign mul_a = w_accept ? in_a : 32'd0;
  assign mul_b = w_accept ? in_b : 32'd0;

  assign w_push    = r_vld_pipe[LATENCY-1];
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid & out_ready;

  assign out_prod = r_mem_prod[r_rd_ptr];
  assign out_tag  = r_mem_tag[r_rd_ptr];
  assign inflight = r_infl;
  assign busy     = (r_infl != '0) | (r_cnt != '0);

  // Valid/tag chain: one slot per multiplier stage, tail marks a ready product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
      r_vld_pipe[0] <= w_accept_d;
      r_tag_pipe[0] <= in_tag;
    end
  end

  // In-flight counter: +1 on accept, -1 when the tail is captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_infl <= '0;
    end else begin
      case ({w_accept_d, w_push})
        2'b10:   r_infl <= r_infl + CW'(1);
        2'b01:   r_infl <= r_infl - CW'(1);
        default: r_infl <= r_infl;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_prod[i] <= '0;
        r_mem_tag[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_prod[r_wr_ptr] <= mul_out;
      r_mem_tag[r_wr_ptr]  <= r_tag_pipe[LATENCY-1];
    end
  end

endmodule
